// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its multiply/divide engine.
// The HI/LO-class decode is only consulted when ALU_MULDIV_EN is defined.
package alu_ctrl_pkg;

  localparam logic [3:0] ALUCTR_AND = 4'b0000;
  localparam logic [3:0] ALUCTR_OR  = 4'b0001;
  localparam logic [3:0] ALUCTR_ADD = 4'b0010;
  localparam logic [3:0] ALUCTR_SUB = 4'b0110;
  localparam logic [3:0] ALUCTR_SLT = 4'b0111;
  localparam logic [3:0] ALUCTR_NOR = 4'b1100;
  localparam logic [3:0] ALUCTR_INV = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Moves are 0100xx and mult/div are 0110xx, so two prefix compares cover all eight.
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/alu_ctrl_md_muldiv.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide over
// operand magnitudes, one bit per cycle, with sign fixup and divide-by-zero override.
module muldiv_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  md_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz;
  logic [WIDTH-1:0]   r_a_orig, r_opnd, r_hw, r_lw;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_hw_nxt, w_lw_nxt, w_quo, w_rem;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic               w_last;

  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_mag_a = (i_signed && i_src_a[WIDTH-1]) ? -i_src_a : i_src_a;
  assign w_mag_b = (i_signed && i_src_b[WIDTH-1]) ? -i_src_b : i_src_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= MD_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nxt = MD_RUN;
      MD_RUN:  if (w_last)  w_state_nxt = MD_DONE;
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // r_hw/r_lw hold {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_sum    = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_opnd} : '0);
  assign w_shift  = {r_hw, r_lw[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_opnd};
  assign w_hw_nxt = r_is_div ? (w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0])
                             : w_sum[WIDTH:1];
  assign w_lw_nxt = r_is_div ? {r_lw[WIDTH-2:0], ~w_diff[WIDTH]}
                             : {w_sum[0], r_lw[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
      r_opnd   <= '0;
      r_hw     <= '0;
      r_lw     <= '0;
    end else if (r_state == MD_IDLE && i_start) begin
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_neg_q  <= i_signed && (i_src_a[WIDTH-1] ^ i_src_b[WIDTH-1]);
      r_neg_r  <= i_signed && i_src_a[WIDTH-1];
      r_dz     <= i_is_div && (i_src_b == '0);
      r_a_orig <= i_src_a;
      r_opnd   <= w_mag_b;
      r_hw     <= '0;
      r_lw     <= w_mag_a;
    end else if (r_state == MD_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_hw  <= w_hw_nxt;
      r_lw  <= w_lw_nxt;
    end
  end

  assign w_prod   = {r_hw, r_lw};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quo    = r_neg_q ? -r_lw : r_lw;
  assign w_rem    = r_neg_r ? -r_hw : r_hw;

  assign o_busy = (r_state != MD_IDLE);
  assign o_done = (r_state == MD_DONE);
  assign o_hi   = r_dz ? r_a_orig : (r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH]);
  assign o_lo   = r_dz ? '1 : (r_is_div ? w_quo : w_prod_s[WIDTH-1:0]);

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decode plus HI/LO registers and the iterative mult/div unit.
// Macro ALU_MULDIV_EN enables the HI/LO-class instructions; undefined ties them off.
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [1:0]       i_aluop,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [3:0]       o_aluctr,
  output logic             o_md_sel,
  output logic [WIDTH-1:0] o_md_result,
  output logic             o_busy,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic w_hilo_funct;
`ifdef ALU_MULDIV_EN
  assign w_hilo_funct = is_hilo_funct(i_funct);
`else
  assign w_hilo_funct = 1'b0;
`endif

  always_comb begin
    o_aluctr = ALUCTR_INV;
    case (i_aluop)
      ALUOP_ADD: o_aluctr = ALUCTR_ADD;
      ALUOP_SUB: o_aluctr = ALUCTR_SUB;
      ALUOP_OR:  o_aluctr = ALUCTR_OR;
      default: begin
        case (i_funct)
          F_ADD:   o_aluctr = ALUCTR_ADD;
          F_SUB:   o_aluctr = ALUCTR_SUB;
          F_AND:   o_aluctr = ALUCTR_AND;
          F_OR:    o_aluctr = ALUCTR_OR;
          F_SLT:   o_aluctr = ALUCTR_SLT;
          F_NOR:   o_aluctr = ALUCTR_NOR;
          default: o_aluctr = w_hilo_funct ? ALUCTR_ADD : ALUCTR_INV;
        endcase
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic             w_hilo, w_accept, w_start, w_is_div, w_signed, w_md_done;
  logic [WIDTH-1:0] w_md_hi, w_md_lo, r_hi, r_lo;

  assign w_hilo   = (i_aluop == ALUOP_RTYPE) && w_hilo_funct;
  assign w_accept = i_valid && w_hilo && !o_busy;
  assign w_is_div = (i_funct == F_DIV) || (i_funct == F_DIVU);
  assign w_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
  assign w_start  = w_accept && (w_is_div || i_funct == F_MULT || i_funct == F_MULTU);

  muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_is_div (w_is_div),
    .i_signed (w_signed),
    .i_src_a  (i_src_a),
    .i_src_b  (i_src_b),
    .o_busy   (o_busy),
    .o_done   (w_md_done),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo)
  );

  assign o_stall     = i_valid && w_hilo && o_busy;
  assign o_md_sel    = w_accept && (i_funct == F_MFHI || i_funct == F_MFLO);
  assign o_md_result = !o_md_sel ? '0 : ((i_funct == F_MFHI) ? r_hi : r_lo);

  // Moves are never accepted while busy, so they cannot collide with the DONE write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_md_done) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (w_accept) begin
      if (i_funct == F_MTHI) r_hi <= i_src_a;
      if (i_funct == F_MTLO) r_lo <= i_src_a;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
`else
  logic             w_unused;
  logic [CNT_W-1:0] w_unused_cnt;

  assign w_unused     = ^{i_clk, i_rst, i_valid, i_src_a, i_src_b};
  assign w_unused_cnt = '0;
  assign o_md_sel     = 1'b0;
  assign o_md_result  = '0;
  assign o_busy       = 1'b0;
  assign o_stall      = 1'b0;
  assign o_hi         = '0;
  assign o_lo         = '0;
`endif

endmodule
